// File: rtl/fa_cell.sv
`default_nettype none
// ============================================================================
//  Module   : fa_cell
//  Purpose  : Single-bit combinational full-adder cell (sum and majority carry).
//  Revision : 1.0  initial release
// ============================================================================
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/full_adder_reg.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder_reg
//  Purpose  : Registered single-bit full adder; one-cycle latency, one result per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module full_adder_reg (
    input  logic clk,
    input  logic rstn,
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    logic w_s_nxt;
    logic w_c_nxt;

    fa_cell u_fa_cell (
        .a    (a),
        .b    (b),
        .cin  (carry_in),
        .s    (w_s_nxt),
        .cout (w_c_nxt)
    );

    // rstn is active-high: inputs seen during a reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (rstn) begin
            sum       <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            sum       <= w_s_nxt;
            carry_out <= w_c_nxt;
        end
    end

`ifdef FORMAL
    logic r_past_valid;

    always_ff @(posedge clk) begin
        if (rstn) r_past_valid <= 1'b1;
        else      r_past_valid <= r_past_valid;
    end

    initial assume (rstn);

    always @(posedge clk) begin
        if (r_past_valid) begin
            if ($past(rstn)) begin
                a1_reset_zero : assert (sum == 1'b0 && carry_out == 1'b0);
            end else begin
                a2_arith : assert ({carry_out, sum} ==
                    (2'($past(a)) + 2'($past(b)) + 2'($past(carry_in))));
            end
            // First cycle after release must still show reset values, not old data.
            if ($past(rstn) && !rstn) begin
                a3_no_stale : assert (sum == 1'b0 && carry_out == 1'b0);
            end
            c_all_ones : cover (!$past(rstn) && {carry_out, sum} == 2'b11);
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_cover_inputs
        always @(posedge clk) begin
            if (r_past_valid) begin
                c_combo : cover (!$past(rstn) &&
                    {$past(a), $past(b), $past(carry_in)} == 3'(k) &&
                    {carry_out, sum} == (2'(k >> 2) + 2'((k >> 1) & 1) + 2'(k & 1)));
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_full_adder_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_full_adder_reg
//  Purpose  : Directed self-checking bench for full_adder_reg.
//  Revision : 1.0  initial release
// ============================================================================
module tb_full_adder_reg;

    logic clk;
    logic rstn;
    logic a;
    logic b;
    logic carry_in;
    logic sum;
    logic carry_out;

    int checks = 0;
    int errors = 0;

    full_adder_reg dut (
        .clk       (clk),
        .rstn      (rstn),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got {carry_out,sum}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, then sample just after the edge.
    task automatic step(input logic r, input logic ia, input logic ib, input logic ic);
        rstn     = r;
        a        = ia;
        b        = ib;
        carry_in = ic;
        @(posedge clk);
        #1;
    endtask

    // Expected {carry_out,sum} for sweep index 0..7 (a,b,cin in binary order).
    logic [1:0] sweep_exp [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    initial begin
        logic [2:0] v;
        rstn = 1'b1; a = 1'b1; b = 1'b1; carry_in = 1'b1;

        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_cycle0", {carry_out, sum}, 2'b00);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_cycle1", {carry_out, sum}, 2'b00);

        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("row_000", {carry_out, sum}, 2'b00);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("row_100", {carry_out, sum}, 2'b01);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("row_110", {carry_out, sum}, 2'b10);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("row_111", {carry_out, sum}, 2'b11);

        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            step(1'b0, v[2], v[1], v[0]);
            check($sformatf("sweep_%0d", i), {carry_out, sum}, sweep_exp[i]);
        end

        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("pre_midreset", {carry_out, sum}, 2'b11);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("midreset_edge", {carry_out, sum}, 2'b00);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_release", {carry_out, sum}, 2'b00);

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                step(1'b0, 1'b1, 1'b1, 1'b1);
                check($sformatf("toggle_%0d", i), {carry_out, sum}, 2'b11);
            end else begin
                step(1'b0, 1'b0, 1'b0, 1'b0);
                check($sformatf("toggle_%0d", i), {carry_out, sum}, 2'b00);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
